mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter sharing the processor's single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store path. Each cycle it grants at most one requester, drives the memory command from the winner, and routes the one-cycle-latency read data back to the owner. It replaces the clock-level address multiplexing used today with an explicit grant/stall handshake into the pipeline.

## Interface
- ADDR_W, 8: memory byte-address width.
- DATA_W, 32: data width.
- STARVE_LIMIT, 4: consecutive data grants with fetch pending before fetch is forced a slot (guard build only).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_kill  in  1  branch/jump flush: drop fetch grant and return this cycle.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_W  instruction word.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store, 0 = load.
- d_func  in  3  funct3 width/sign code, passed to memory.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- mem_re, mem_we  out  1  memory read/write strobes.
- mem_func  out  3  width code to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_re.
- if_stall  out  1  if_req & ~if_gnt; holds PC and IF/ID.

## Operation
- Grant logic combinational. Default priority: data over fetch (older instruction).
- d_gnt = d_req & ~force_if; if_gnt = if_req & ~if_kill & ~d_gnt.
- Winner drives mem_addr/mem_func/mem_wdata; mem_re = granted load or fetch; mem_we = granted store. Fetch uses mem_func = 3'b010 (word). No grant: strobes 0, address/data 0.
- Owner register {OWN_NONE, OWN_IF, OWN_D} records owner of the read issued this cycle; stores and idle cycles load OWN_NONE.
- Next cycle: OWN_IF -> if_rvalid=1, if_rdata=mem_rdata; OWN_D -> d_rvalid=1, d_rdata=mem_rdata. rdata outputs 0 when not valid.
- if_kill in cycle N: if_gnt=0 and if_rvalid=0 in N (kills fetch issued in N-1). Data path unaffected.
- Back-to-back: new grant allowed in the same cycle a previous read returns; full throughput one access/cycle.
- Stores complete at the granting edge; never raise rvalid.

## Timing
- Reset (rst low, async): owner=OWN_NONE, starve count=0, if_rvalid=d_rvalid=0, rdata=0; mem_re/mem_we forced 0 while rst low; gnts 0.
- Grant latency 0 cycles (same cycle as req). Read latency 1 cycle grant->rvalid.
- Simultaneous if_req & d_req: data granted, if_stall=1 that cycle.
- if_kill with no outstanding fetch: no effect beyond blocking if_gnt.
- Reset mid-access: pending return discarded; first grant allowed the cycle after rst rises.

## Configuration
- ARB_STARVE_GUARD_EN defined: counter increments on each cycle with d_gnt & if_req & ~if_kill, clears on any if_gnt or when if_req low; when count == STARVE_LIMIT, force_if=1 for one cycle, fetch wins over data, counter clears.
- Undefined: force_if tied 0, no counter; strict data priority.

## Structure
- Shared package: owner enum (OWN_NONE/OWN_IF/OWN_D), funct3 width constants (LB/LH/LW/LBU/LHU, SB/SH/SW), FETCH_FUNC=3'b010.
- One sub-module natural: arb_starve_counter (guard counter and force_if), instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Reset: rst low with if_req=1 -> mem_re=0, if_gnt=0, all rvalid 0; after release fetch addr 0x04 -> if_gnt same cycle, if_rvalid next cycle with mem_rdata.
- Collision: if_req addr 0x10 and d_req load 0x80 same cycle -> d_gnt=1, if_stall=1; d_rvalid next cycle; if_gnt next cycle.
- Store: d_req d_we=1 d_func=SB addr 0x81 wdata 0xAB -> mem_we=1, mem_func=000, no d_rvalid.
- Kill: fetch 0x20 granted in N, if_kill in N+1 -> if_rvalid stays 0, if_gnt=0 in N+1.
- Back-to-back: alternating fetch/load every cycle -> one grant per cycle, rvalid routed to correct owner each cycle.
- Guard (macro on, STARVE_LIMIT=4): d_req and if_req held high -> 4 d_gnts then one if_gnt, repeat; macro off -> if_gnt never asserts.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Contents: read-owner enum, funct3 width/sign codes, fetch width code.
package mem_port_arbiter_pkg;

  // Who issued the read whose data returns on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // funct3 width/sign codes as the load/store unit presents them.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Instruction fetches are always full words.
  localparam logic [2:0] FETCH_FUNC = LW;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory signal bundle for the memory port arbiter
// Groups: fetch port (if_*), load/store port (d_*), memory command/response (mem_*), if_stall.
// slave modport is the arbiter's view; master modport is the pipeline + memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_re;
  logic              mem_we;
  logic [2:0]        mem_func;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    input  d_req, d_we, d_func, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_re, mem_we, mem_func, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    output d_req, d_we, d_func, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_re, mem_we, mem_func, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - fetch starvation guard for the memory port arbiter
// Ports: clk, rst (async active-low), d_gnt/if_gnt (this cycle's grants),
// if_req/if_kill (fetch request state), force_if (give the port to fetch this cycle).
module arb_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_gnt,
  input  logic if_req,
  input  logic if_kill,
  input  logic if_gnt,
  output logic force_if
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // force_if does not depend on d_gnt, so there is no loop through the grant logic.
  assign force_if = if_req & ~if_kill & (cnt == CNT_W'(LIMIT));

  // A forced slot produces if_gnt, which clears the count; a killed cycle
  // holds the count so the forced slot lands on the next live fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (if_gnt | ~if_req) begin
      cnt <= '0;
    end else if (d_gnt & ~if_kill) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
// Ports: clk, rst (async active-low), bus (mem_port_arbiter_if.slave: fetch, data, memory, if_stall).
// Optional build macro ARB_STARVE_GUARD_EN adds a fetch starvation guard (STARVE_LIMIT).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  owner_e owner_q;
  owner_e owner_d;
  logic   force_if;
  logic   d_gnt;
  logic   if_gnt;
  logic   if_rvalid;
  logic   d_rvalid;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .d_gnt    (d_gnt),
    .if_req   (bus.if_req),
    .if_kill  (bus.if_kill),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Grants are gated by rst so nothing reaches memory while reset is held.
  assign d_gnt  = rst & bus.d_req & ~force_if;
  assign if_gnt = rst & bus.if_req & ~bus.if_kill & ~d_gnt;

  // A kill this cycle flushes the fetch issued last cycle.
  assign if_rvalid = (owner_q == OWN_IF) & ~bus.if_kill;
  assign d_rvalid  = (owner_q == OWN_D);

  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_func  = 3'b000;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    owner_d       = OWN_NONE;
    if (d_gnt) begin
      bus.mem_re    = ~bus.d_we;
      bus.mem_we    = bus.d_we;
      bus.mem_func  = bus.d_func;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      owner_d       = bus.d_we ? OWN_NONE : OWN_D;
    end else if (if_gnt) begin
      bus.mem_re    = 1'b1;
      bus.mem_func  = FETCH_FUNC;
      bus.mem_addr  = bus.if_addr;
      owner_d       = OWN_IF;
    end
  end

  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.if_stall  = bus.if_req & ~if_gnt;
    bus.if_rvalid = if_rvalid;
    bus.if_rdata  = if_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.d_rvalid  = d_rvalid;
    bus.d_rdata   = d_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] shadow  [256];
  logic [31:0] rd_next;

  logic        s_rst, s_if_req, s_if_kill, s_d_req, s_d_we;
  logic [7:0]  s_if_addr, s_d_addr;
  logic [2:0]  s_d_func;
  logic [31:0] s_d_wdata;

  typedef enum {P_NONE, P_IF, P_D} pend_e;
  pend_e       pend;
  logic [31:0] pend_data;

  logic        e_dg, e_ig, e_force;
`ifdef ARB_STARVE_GUARD_EN
  localparam int GUARD_LIMIT = 4;
  int starve = 0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic ifr, input logic [7:0] ifa, input logic kill,
                        input logic dr, input logic we, input logic [2:0] fn,
                        input logic [7:0] da, input logic [31:0] wd);
    s_rst = r; s_if_req = ifr; s_if_addr = ifa; s_if_kill = kill;
    s_d_req = dr; s_d_we = we; s_d_func = fn; s_d_addr = da; s_d_wdata = wd;
  endtask

  // Expected outputs from the arbitration rules and the outstanding read.
  task automatic model_check();
    logic        e_re, e_we, e_irv, e_drv;
    logic [7:0]  e_addr;
    logic [2:0]  e_func;
    logic [31:0] e_wdata;
    e_force = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    e_force = (starve == GUARD_LIMIT) && bus.if_req && !bus.if_kill;
`endif
    e_dg    = rst && bus.d_req && !e_force;
    e_ig    = rst && bus.if_req && !bus.if_kill && !e_dg;
    e_re    = e_ig || (e_dg && !bus.d_we);
    e_we    = e_dg && bus.d_we;
    e_addr  = e_dg ? bus.d_addr : (e_ig ? bus.if_addr : 8'h00);
    e_func  = e_dg ? bus.d_func : (e_ig ? 3'b010 : 3'b000);
    e_wdata = e_dg ? bus.d_wdata : 32'h0;
    e_irv   = rst && (pend == P_IF) && !bus.if_kill;
    e_drv   = rst && (pend == P_D);
    chk("d_gnt",     64'(bus.d_gnt),     64'(e_dg));
    chk("if_gnt",    64'(bus.if_gnt),    64'(e_ig));
    chk("if_stall",  64'(bus.if_stall),  64'(bus.if_req && !e_ig));
    chk("mem_re",    64'(bus.mem_re),    64'(e_re));
    chk("mem_we",    64'(bus.mem_we),    64'(e_we));
    chk("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
    chk("mem_func",  64'(bus.mem_func),  64'(e_func));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
    chk("if_rvalid", 64'(bus.if_rvalid), 64'(e_irv));
    chk("if_rdata",  64'(bus.if_rdata),  64'(e_irv ? pend_data : 32'h0));
    chk("d_rvalid",  64'(bus.d_rvalid),  64'(e_drv));
    chk("d_rdata",   64'(bus.d_rdata),   64'(e_drv ? pend_data : 32'h0));
  endtask

  // Advance the model past the clock edge; also act as the memory behind the port.
  task automatic model_update();
    if (!rst) begin
      pend = P_NONE;
    end else if (e_dg && bus.d_we) begin
      shadow[bus.d_addr] = bus.d_wdata;
      pend = P_NONE;
    end else if (e_dg) begin
      pend = P_D;
      pend_data = shadow[bus.d_addr];
    end else if (e_ig) begin
      pend = P_IF;
      pend_data = shadow[bus.if_addr];
    end else begin
      pend = P_NONE;
    end
`ifdef ARB_STARVE_GUARD_EN
    if (!rst || e_ig || !bus.if_req) starve = 0;
    else if (e_dg && !bus.if_kill) starve++;
`endif
    if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
    rd_next = bus.mem_re ? mem_arr[bus.mem_addr] : $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst           = s_rst;
    bus.if_req    = s_if_req;
    bus.if_addr   = s_if_addr;
    bus.if_kill   = s_if_kill;
    bus.d_req     = s_d_req;
    bus.d_we      = s_d_we;
    bus.d_func    = s_d_func;
    bus.d_addr    = s_d_addr;
    bus.d_wdata   = s_d_wdata;
    bus.mem_rdata = rd_next;
    @(negedge clk);
    model_check();
    model_update();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'h1000_0000 | i;
      shadow[i]  = 32'h1000_0000 | i;
    end
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_func = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;
    rd_next = '0;
    pend = P_NONE;
    pend_data = '0;
    e_dg = 1'b0; e_ig = 1'b0; e_force = 1'b0;

    // Reset held with a fetch pending.
    set_in(0, 1, 8'h04, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("rst_mem_re", 64'(bus.mem_re), 64'd0);
    chk("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'd0);

    // First fetch right after release.
    set_in(1, 1, 8'h04, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("fetch04_gnt", 64'(bus.if_gnt), 64'd1);
    chk("fetch04_addr", 64'(bus.mem_addr), 64'h04);

    // Collision: data wins, fetch stalls; fetch 0x04 returns.
    set_in(1, 1, 8'h10, 0, 1, 0, LW, 8'h80, 32'h0); step();
    chk("fetch04_rdata", 64'(bus.if_rdata), 64'h1000_0004);
    chk("coll_d_gnt", 64'(bus.d_gnt), 64'd1);
    chk("coll_if_stall", 64'(bus.if_stall), 64'd1);
    chk("coll_addr", 64'(bus.mem_addr), 64'h80);

    set_in(1, 1, 8'h10, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("load80_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("load80_rdata", 64'(bus.d_rdata), 64'h1000_0080);
    chk("fetch10_gnt", 64'(bus.if_gnt), 64'd1);

    // Byte store.
    set_in(1, 0, 8'h00, 0, 1, 1, SB, 8'h81, 32'hAB); step();
    chk("fetch10_rdata", 64'(bus.if_rdata), 64'h1000_0010);
    chk("store_we", 64'(bus.mem_we), 64'd1);
    chk("store_re", 64'(bus.mem_re), 64'd0);
    chk("store_func", 64'(bus.mem_func), 64'(3'b000));
    chk("store_wdata", 64'(bus.mem_wdata), 64'hAB);

    set_in(1, 0, 8'h00, 0, 1, 0, LBU, 8'h81, 32'h0); step();
    chk("store_no_rvalid", 64'(bus.d_rvalid), 64'd0);
    set_in(1, 0, 8'h00, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("load81_rdata", 64'(bus.d_rdata), 64'hAB);

    // Kill: fetch 0x20 issued, flushed the next cycle.
    set_in(1, 1, 8'h20, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("fetch20_gnt", 64'(bus.if_gnt), 64'd1);
    set_in(1, 1, 8'h24, 1, 0, 0, LW, 8'h00, 32'h0); step();
    chk("kill_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("kill_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    set_in(1, 0, 8'h00, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("kill_after_rvalid", 64'(bus.if_rvalid), 64'd0);

    // Back-to-back alternating fetch/load.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) set_in(1, 1, 8'(8'h30 + 4 * k), 0, 0, 0, LW, 8'h00, 32'h0);
      else            set_in(1, 0, 8'h00, 0, 1, 0, LW, 8'(8'h40 + k), 32'h0);
      step();
      chk("b2b_one_grant", 64'(bus.if_gnt + bus.d_gnt), 64'd1);
      if (k > 0) chk("b2b_one_return", 64'(bus.if_rvalid + bus.d_rvalid), 64'd1);
    end

    // Reset in the cycle a load would return.
    set_in(1, 0, 8'h00, 0, 1, 0, LW, 8'h42, 32'h0); step();
    set_in(0, 0, 8'h00, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("rst_mid_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    set_in(1, 1, 8'h08, 0, 0, 0, LW, 8'h00, 32'h0); step();
    chk("post_rst_if_gnt", 64'(bus.if_gnt), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s_rst     = ($urandom_range(0, 59) != 0);
      s_if_req  = ($urandom_range(0, 9) < 6);
      s_if_addr = 8'($urandom_range(0, 255));
      s_if_kill = ($urandom_range(0, 9) == 0);
      s_d_req   = ($urandom_range(0, 9) < 5);
      s_d_we    = ($urandom_range(0, 9) < 4);
      s_d_func  = 3'($urandom_range(0, 7));
      s_d_addr  = ($urandom_range(0, 1) == 0) ? 8'(8'h80 | $urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      s_d_wdata = $urandom;
      step();
    end

    // Data and fetch held high together.
    set_in(1, 0, 8'h00, 0, 0, 0, LW, 8'h00, 32'h0); step();
    for (int k = 0; k < 15; k++) begin
      set_in(1, 1, 8'h50, 0, 1, 0, LW, 8'h60, 32'h0); step();
`ifdef ARB_STARVE_GUARD_EN
      chk("held_if_gnt", 64'(bus.if_gnt), 64'((k % 5) == 4));
`else
      chk("held_if_gnt", 64'(bus.if_gnt), 64'd0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
